// File: rtl/me_frame_scheduler_if.sv
// Scheduler-side bus towards the window loader, the ME core and the result buffer.
interface me_frame_scheduler_if #(
  parameter int unsigned MBX_W  = 6,
  parameter int unsigned MBY_W  = 6,
  parameter int unsigned RES_AW = 12
) ();
  logic [MBX_W-1:0]  mb_x;
  logic [MBY_W-1:0]  mb_y;
  logic              load_req;
  logic              load_ack;
  logic              me_req;
  logic              me_ack;
  logic [15:0]       me_min_sad;
  logic [11:0]       me_min_mvec;
  logic              res_we;
  logic [RES_AW-1:0] res_addr;
  logic [27:0]       res_data;

  modport master (
    output mb_x, mb_y, load_req, me_req, res_we, res_addr, res_data,
    input  load_ack, me_ack, me_min_sad, me_min_mvec
  );

  modport slave (
    input  mb_x, mb_y, load_req, me_req, res_we, res_addr, res_data,
    output load_ack, me_ack, me_min_sad, me_min_mvec
  );
endinterface

// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer: walks all MBs in raster order through load, ME search and result write.
// Optional SAD accumulator output (sum_sad) is built when ME_SAD_ACCUM_EN is defined.
module me_frame_scheduler #(
  parameter int unsigned MBX_W  = 6,
  parameter int unsigned MBY_W  = 6,
  parameter int unsigned RES_AW = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MBX_W-1:0] mb_cols,
  input  logic [MBY_W-1:0] mb_rows,
  output logic             busy,
  output logic             done,
`ifdef ME_SAD_ACCUM_EN
  output logic [31:0]      sum_sad,
`endif
  me_frame_scheduler_if.master bus
);

  localparam int unsigned SAD_W = 16;
  localparam int unsigned MV_W  = 12;
  localparam int unsigned RD_W  = SAD_W + MV_W;
`ifdef ME_SAD_ACCUM_EN
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned ACCX_W = ACC_W + 1;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEARCH = 3'd2,
    WRITE  = 3'd3,
    NEXT   = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_req_q, load_req_d;
  logic              me_req_q, me_req_d;
  logic              we_q, we_d;
  logic [MBX_W-1:0]  cols_q, cols_d;
  logic [MBY_W-1:0]  rows_q, rows_d;
  logic [MBX_W-1:0]  x_q, x_d;
  logic [MBY_W-1:0]  y_q, y_d;
  logic [RES_AW-1:0] addr_q, addr_d;
  logic [RD_W-1:0]   data_q, data_d;
  logic              last_x, last_y;
`ifdef ME_SAD_ACCUM_EN
  logic [ACC_W-1:0]  sum_sad_q, sum_sad_d;
  logic [ACCX_W-1:0] sum_ext;
`endif

  assign last_x = (x_q == cols_q - MBX_W'(1));
  assign last_y = (y_q == rows_q - MBY_W'(1));

`ifdef ME_SAD_ACCUM_EN
  // Saturating add of the captured SAD; carry out means clamp.
  assign sum_ext = {1'b0, sum_sad_q} + ACCX_W'(data_q[RD_W-1:MV_W]);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (mb_cols == '0 || mb_rows == '0) ? FIN : LOAD;
      LOAD:    if (bus.load_ack) state_d = SEARCH;
      SEARCH:  if (bus.me_ack) state_d = WRITE;
      WRITE:   state_d = NEXT;
      NEXT:    state_d = (last_x && last_y) ? FIN : LOAD;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; requests follow the state being entered
  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    cols_d     = cols_q;
    rows_d     = rows_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    data_d     = data_q;
    load_req_d = (state_d == LOAD);
    me_req_d   = (state_d == SEARCH);
    we_d       = (state_d == WRITE);
`ifdef ME_SAD_ACCUM_EN
    sum_sad_d  = sum_sad_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cols_d = mb_cols;
          rows_d = mb_rows;
          x_d    = '0;
          y_d    = '0;
          addr_d = '0;
`ifdef ME_SAD_ACCUM_EN
          sum_sad_d = '0;
`endif
        end
      end
      SEARCH: begin
        if (bus.me_ack) data_d = {bus.me_min_sad, bus.me_min_mvec};
      end
      WRITE: begin
`ifdef ME_SAD_ACCUM_EN
        sum_sad_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`endif
      end
      NEXT: begin
        addr_d = addr_q + RES_AW'(1);
        if (last_x) begin
          x_d = '0;
          if (!last_y) y_d = y_q + MBY_W'(1);
        end else begin
          x_d = x_q + MBX_W'(1);
        end
      end
      FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_req_q <= 1'b0;
      me_req_q   <= 1'b0;
      we_q       <= 1'b0;
      cols_q     <= '0;
      rows_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef ME_SAD_ACCUM_EN
      sum_sad_q  <= '0;
`endif
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_req_q <= load_req_d;
      me_req_q   <= me_req_d;
      we_q       <= we_d;
      cols_q     <= cols_d;
      rows_q     <= rows_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
`ifdef ME_SAD_ACCUM_EN
      sum_sad_q  <= sum_sad_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.load_req  = load_req_q;
  assign bus.me_req    = me_req_q;
  assign bus.res_we    = we_q;
  assign bus.res_addr  = addr_q;
  assign bus.res_data  = data_q;
  assign bus.mb_x      = x_q;
  assign bus.mb_y      = y_q;
`ifdef ME_SAD_ACCUM_EN
  assign sum_sad       = sum_sad_q;
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Directed bench for me_frame_scheduler: frame walks, empty frame, busy start, reset, ack corner cases.
module tb_me_frame_scheduler;

  localparam int unsigned MBX_W  = 6;
  localparam int unsigned MBY_W  = 6;
  localparam int unsigned RES_AW = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [MBX_W-1:0] mb_cols;
  logic [MBY_W-1:0] mb_rows;
  logic             busy;
  logic             done;
`ifdef ME_SAD_ACCUM_EN
  logic [31:0]      sum_sad;
`endif

  me_frame_scheduler_if #(.MBX_W(MBX_W), .MBY_W(MBY_W), .RES_AW(RES_AW)) bus ();

  me_frame_scheduler #(.MBX_W(MBX_W), .MBY_W(MBY_W), .RES_AW(RES_AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mb_cols (mb_cols),
    .mb_rows (mb_rows),
    .busy    (busy),
    .done    (done),
`ifdef ME_SAD_ACCUM_EN
    .sum_sad (sum_sad),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Ack sources: automatic responder or manual drive from the tasks
  bit          auto_en = 1'b0;
  bit          sad_fixed = 1'b0;
  int unsigned load_dly = 3;
  int unsigned me_dly = 10;
  logic        a_load_ack, a_me_ack, m_load_ack, m_me_ack;
  logic [15:0] a_sad, m_sad;
  logic [11:0] a_mvec, m_mvec;
  int unsigned me_n = 0;
  int unsigned ld_w = 0;
  int unsigned me_w = 0;

  assign bus.load_ack    = auto_en ? a_load_ack : m_load_ack;
  assign bus.me_ack      = auto_en ? a_me_ack   : m_me_ack;
  assign bus.me_min_sad  = auto_en ? a_sad      : m_sad;
  assign bus.me_min_mvec = auto_en ? a_mvec     : m_mvec;

  initial begin
    a_load_ack = 1'b0; a_me_ack = 1'b0; a_sad = '0; a_mvec = '0;
    forever begin
      @(posedge clk); #1;
      a_load_ack = 1'b0;
      a_me_ack   = 1'b0;
      if (bus.load_req) begin
        if (ld_w == load_dly) begin a_load_ack = 1'b1; ld_w = 0; end
        else ld_w++;
      end else ld_w = 0;
      if (bus.me_req) begin
        if (me_w == me_dly) begin
          a_me_ack = 1'b1;
          a_sad    = sad_fixed ? 16'hFFFF : 16'(32'h0100 + me_n);
          a_mvec   = 12'(32'h00A0 + me_n);
          if (auto_en) me_n++;
          me_w = 0;
        end else me_w++;
      end else me_w = 0;
    end
  end

  // Passive monitor
  logic [RES_AW-1:0] we_addr [128];
  logic [27:0]       we_data [128];
  logic [MBX_W-1:0]  we_x    [128];
  logic [MBY_W-1:0]  we_y    [128];
  int                we_cyc  [128];
  int                ack_cyc [128];
  int we_n = 0, ack_n = 0, done_n = 0, lreq_n = 0, mreq_n = 0, ovl_n = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.res_we && we_n < 128) begin
      we_addr[we_n] <= bus.res_addr;
      we_data[we_n] <= bus.res_data;
      we_x[we_n]    <= bus.mb_x;
      we_y[we_n]    <= bus.mb_y;
      we_cyc[we_n]  <= cyc;
      we_n          <= we_n + 1;
    end
    if (bus.me_req && bus.me_ack && ack_n < 128) begin
      ack_cyc[ack_n] <= cyc;
      ack_n          <= ack_n + 1;
    end
    if (done)                      done_n <= done_n + 1;
    if (bus.load_req)              lreq_n <= lreq_n + 1;
    if (bus.me_req)                mreq_n <= mreq_n + 1;
    if (bus.load_req && bus.me_req) ovl_n <= ovl_n + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    n_run++;
    if ({busy, done, bus.load_req, bus.me_req, bus.res_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, bus.load_req, bus.me_req, bus.res_we});
    end
    n_run++;
    if (bus.res_addr !== '0 || bus.res_data !== '0) begin
      n_fail++; $display("FAIL reset_res: addr=%0h data=%0h expected 0/0", bus.res_addr, bus.res_data);
    end
    n_run++;
    if (bus.mb_x !== '0 || bus.mb_y !== '0) begin
      n_fail++; $display("FAIL reset_xy: x=%0d y=%0d expected 0/0", bus.mb_x, bus.mb_y);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (busy !== 1'b0 || bus.load_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b load_req=%b expected 0/0", busy, bus.load_req);
    end
  endtask

  task automatic test_frame_2x2();
    int wb, ab, db, ob;
    int unsigned nb;
    bit got;
    logic [27:0] exp_d;
    auto_en = 1'b1; load_dly = 3; me_dly = 10; sad_fixed = 1'b0;
    wb = we_n; ab = ack_n; db = done_n; ob = ovl_n; nb = me_n;
    @(negedge clk); #1 start = 1'b1; mb_cols = 6'd2; mb_rows = 6'd2;
    @(negedge clk);
    n_run++;
    if (bus.load_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL f22_start_lat: load_req=%b busy=%b expected 1/1", bus.load_req, busy);
    end
    #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    n_run++;
    if (!got || busy !== 1'b0) begin
      n_fail++; $display("FAIL f22_done: done_seen=%b busy=%b expected 1/0", got, busy);
    end
    repeat (3) @(negedge clk);
    n_run++;
    if (done_n - db != 1 || we_n - wb != 4) begin
      n_fail++; $display("FAIL f22_counts: done=%0d we=%0d expected 1/4", done_n - db, we_n - wb);
    end
    for (int k = 0; k < 4; k++) begin
      exp_d = {16'(32'h0100 + nb + k), 12'(32'h00A0 + nb + k)};
      n_run++;
      if (we_addr[wb+k] !== RES_AW'(k) || we_data[wb+k] !== exp_d) begin
        n_fail++; $display("FAIL f22_write%0d: addr=%0h data=%0h expected %0h/%0h", k, we_addr[wb+k], we_data[wb+k], k, exp_d);
      end
      n_run++;
      if (we_x[wb+k] !== MBX_W'(k % 2) || we_y[wb+k] !== MBY_W'(k / 2)) begin
        n_fail++; $display("FAIL f22_xy%0d: got (%0d,%0d) expected (%0d,%0d)", k, we_x[wb+k], we_y[wb+k], k % 2, k / 2);
      end
      n_run++;
      if (we_cyc[wb+k] != ack_cyc[ab+k] + 1) begin
        n_fail++; $display("FAIL f22_ack2we%0d: we_cycle=%0d expected %0d", k, we_cyc[wb+k], ack_cyc[ab+k] + 1);
      end
    end
    n_run++;
    if (ovl_n != ob) begin
      n_fail++; $display("FAIL f22_overlap: overlap cycles=%0d expected 0", ovl_n - ob);
    end
  endtask

  task automatic test_empty_frame();
    int lb, mb, wb, db;
    lb = lreq_n; mb = mreq_n; wb = we_n; db = done_n;
    @(negedge clk); #1 start = 1'b1; mb_cols = 6'd0; mb_rows = 6'd5;
    @(negedge clk);
    n_run++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL empty_c1: done=%b busy=%b expected 0/1", done, busy);
    end
    #1 start = 1'b0;
    @(negedge clk);
    n_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL empty_c2: done=%b busy=%b expected 1/0", done, busy);
    end
    repeat (3) @(negedge clk);
    n_run++;
    if (lreq_n != lb || mreq_n != mb || we_n != wb || done_n - db != 1) begin
      n_fail++; $display("FAIL empty_quiet: lreq=%0d mreq=%0d we=%0d done=%0d expected 0/0/0/1",
                         lreq_n - lb, mreq_n - mb, we_n - wb, done_n - db);
    end
  endtask

  task automatic test_start_busy();
    int wb;
    bit got;
    auto_en = 1'b1; load_dly = 3; me_dly = 10;
    wb = we_n;
    @(negedge clk); #1 start = 1'b1; mb_cols = 6'd2; mb_rows = 6'd2;
    @(negedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.me_req === 1'b1) begin got = 1'b1; break; end
    end
    n_run++;
    if (!got) begin n_fail++; $display("FAIL busy_wait_me: me_req=%b expected 1", bus.me_req); end
    #1 start = 1'b1; mb_cols = 6'd7; mb_rows = 6'd7;
    @(negedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    n_run++;
    if (!got || we_n - wb != 4) begin
      n_fail++; $display("FAIL busy_len: done_seen=%b we=%0d expected 1/4", got, we_n - wb);
    end
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (we_addr[wb+k] !== RES_AW'(k) || we_x[wb+k] !== MBX_W'(k % 2) || we_y[wb+k] !== MBY_W'(k / 2)) begin
        n_fail++; $display("FAIL busy_mb%0d: addr=%0d xy=(%0d,%0d) expected %0d (%0d,%0d)",
                           k, we_addr[wb+k], we_x[wb+k], we_y[wb+k], k, k % 2, k / 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wb;
    bit got;
    auto_en = 1'b1; load_dly = 3; me_dly = 10;
    @(negedge clk); #1 start = 1'b1; mb_cols = 6'd2; mb_rows = 6'd2;
    @(negedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.me_req === 1'b1) begin got = 1'b1; break; end
    end
    #1 rst_n = 1'b0;
    #1;
    n_run++;
    if (!got || {busy, done, bus.load_req, bus.me_req, bus.res_we} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: me_seen=%b ctrl=%b expected 1/00000", got,
                         {busy, done, bus.load_req, bus.me_req, bus.res_we});
    end
    n_run++;
    if (bus.res_addr !== '0 || bus.res_data !== '0 || bus.mb_x !== '0 || bus.mb_y !== '0) begin
      n_fail++; $display("FAIL rstmid_data: addr=%0h data=%0h x=%0d y=%0d expected all 0",
                         bus.res_addr, bus.res_data, bus.mb_x, bus.mb_y);
    end
    auto_en = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    wb = we_n;
    @(negedge clk); #1 m_me_ack = 1'b1; m_sad = 16'h1234; m_mvec = 12'h321;
    @(negedge clk); #1 m_me_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if (we_n != wb || busy !== 1'b0 || bus.me_req !== 1'b0 || bus.load_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: we=%0d busy=%b me_req=%b load_req=%b expected 0/0/0/0",
                         we_n - wb, busy, bus.me_req, bus.load_req);
    end
  endtask

  task automatic test_spurious_acks();
    int wb;
    bit got;
    auto_en = 1'b0;
    wb = we_n;
    @(negedge clk); #1 m_me_ack = 1'b1; m_load_ack = 1'b1;
    @(negedge clk); #1 m_me_ack = 1'b0; m_load_ack = 1'b0;
    @(negedge clk);
    n_run++;
    if (busy !== 1'b0 || bus.load_req !== 1'b0 || bus.me_req !== 1'b0 || we_n != wb) begin
      n_fail++; $display("FAIL sp_idle: busy=%b load_req=%b me_req=%b we=%0d expected 0/0/0/0",
                         busy, bus.load_req, bus.me_req, we_n - wb);
    end
    #1 start = 1'b1; mb_cols = 6'd2; mb_rows = 6'd1;
    @(negedge clk);
    #1 start = 1'b0; m_me_ack = 1'b1;
    @(negedge clk);
    n_run++;
    if (bus.load_req !== 1'b1 || bus.me_req !== 1'b0) begin
      n_fail++; $display("FAIL sp_me_in_load: load_req=%b me_req=%b expected 1/0", bus.load_req, bus.me_req);
    end
    #1 m_me_ack = 1'b0; m_load_ack = 1'b1;
    @(negedge clk);
    n_run++;
    if (bus.me_req !== 1'b1 || bus.load_req !== 1'b0) begin
      n_fail++; $display("FAIL sp_to_search: me_req=%b load_req=%b expected 1/0", bus.me_req, bus.load_req);
    end
    #1 m_load_ack = 1'b0; m_me_ack = 1'b1; m_sad = 16'hBEEF; m_mvec = 12'h5A5;
    @(negedge clk);
    n_run++;
    if (bus.res_we !== 1'b1 || bus.res_data !== {16'hBEEF, 12'h5A5} || bus.res_addr !== '0) begin
      n_fail++; $display("FAIL sp_write: we=%b data=%0h addr=%0h expected 1/beef5a5/0",
                         bus.res_we, bus.res_data, bus.res_addr);
    end
    #1 m_me_ack = 1'b0;
    @(negedge clk);
    n_run++;
    if (bus.res_we !== 1'b0 || bus.load_req !== 1'b0) begin
      n_fail++; $display("FAIL sp_next: we=%b load_req=%b expected 0/0", bus.res_we, bus.load_req);
    end
    @(negedge clk);
    n_run++;
    if (bus.load_req !== 1'b1 || bus.mb_x !== MBX_W'(1) || bus.res_addr !== RES_AW'(1)) begin
      n_fail++; $display("FAIL sp_mb1_load: load_req=%b x=%0d addr=%0d expected 1/1/1",
                         bus.load_req, bus.mb_x, bus.res_addr);
    end
    #1 m_load_ack = 1'b1;
    @(negedge clk);
    n_run++;
    if (bus.me_req !== 1'b1) begin
      n_fail++; $display("FAIL sp_same_cycle: me_req=%b expected 1", bus.me_req);
    end
    #1 m_load_ack = 1'b0; m_me_ack = 1'b1; m_sad = 16'h0042; m_mvec = 12'h011;
    @(negedge clk); #1 m_me_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    n_run++;
    if (!got || we_n - wb != 2) begin
      n_fail++; $display("FAIL sp_done: done_seen=%b we=%0d expected 1/2", got, we_n - wb);
    end
  endtask

`ifdef ME_SAD_ACCUM_EN
  task automatic test_sad_accum();
    bit got;
    auto_en = 1'b1; sad_fixed = 1'b1; load_dly = 1; me_dly = 2;
    @(negedge clk); #1 start = 1'b1; mb_cols = 6'd1; mb_rows = 6'd3;
    @(negedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    n_run++;
    if (!got || sum_sad !== 32'h0002_FFFD) begin
      n_fail++; $display("FAIL acc_sum: done_seen=%b sum=%0h expected 1/2fffd", got, sum_sad);
    end
    #1 start = 1'b1; mb_cols = 6'd1; mb_rows = 6'd1;
    @(negedge clk);
    n_run++;
    if (sum_sad !== 32'h0) begin n_fail++; $display("FAIL acc_clear: sum=%0h expected 0", sum_sad); end
    #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.me_req === 1'b1) begin got = 1'b1; break; end
    end
    force dut.sum_sad_q = 32'hFFFF_FF00;
    @(negedge clk);
    release dut.sum_sad_q;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    repeat (2) @(negedge clk);
    n_run++;
    if (!got || sum_sad !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL acc_sat: me_seen=%b sum=%0h expected 1/ffffffff", got, sum_sad);
    end
    sad_fixed = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; mb_cols = '0; mb_rows = '0;
    m_load_ack = 1'b0; m_me_ack = 1'b0; m_sad = '0; m_mvec = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_frame_2x2();
    test_empty_frame();
    test_start_busy();
    test_reset_mid();
    test_spurious_acks();
`ifdef ME_SAD_ACCUM_EN
    test_sad_accum();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/me_frame_scheduler.md
Name: me_frame_scheduler

Overview:
- Frame-level sequencer in front of the motion-estimation core (req/ack, min_sad, min_mvec).
- Walks every macroblock of a frame in raster order. For each MB it:
  - requests the window/template loader to fill the pel memories,
  - runs one ME search,
  - writes {min_sad, min_mvec} to a result buffer.
- Owned by the host-side control path; a single start pulse processes a whole frame.

Parameters:
- MBX_W, 6, width of MB column count/index.
- MBY_W, 6, width of MB row count/index.
- RES_AW, 12, result-buffer address width (must be >= MBX_W+MBY_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start pulse; ignored while busy.
- mb_cols  in  MBX_W  MBs per row; latched on accepted start.
- mb_rows  in  MBY_W  MB rows; latched on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the frame completes.
- mb_x  out  MBX_W  current MB column, to loader.
- mb_y  out  MBY_W  current MB row, to loader.
- load_req  out  1  loader request, level.
- load_ack  in  1  loader completion, one-cycle pulse.
- me_req  out  1  ME core request, level.
- me_ack  in  1  ME core completion, one-cycle pulse.
- me_min_sad  in  16  SAD, valid when me_ack=1.
- me_min_mvec  in  12  motion vector, valid when me_ack=1.
- res_we  out  1  result write strobe.
- res_addr  out  RES_AW  result address (raster MB index).
- res_data  out  28  {sad[15:0], mvec[11:0]}.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched dims 0. Reset is asynchronous and may occur in any state. On reset:
  - load_req and me_req drop immediately;
  - no res_we is issued;
  - done is not pulsed.
- States: IDLE, LOAD, SEARCH, WRITE, NEXT, FIN.
- IDLE:
  - start=1 latches mb_cols/mb_rows, clears mb_x, mb_y and res_addr, and sets busy.
  - If mb_cols==0 or mb_rows==0, go to FIN. Otherwise go to LOAD.
- LOAD:
  - load_req=1, held until load_ack is sampled high.
  - On that edge load_req drops and the FSM goes to SEARCH.
- SEARCH:
  - me_req=1, held until me_ack is sampled high.
  - On that edge me_req drops and {me_min_sad, me_min_mvec} is captured into res_data. Go to WRITE.
- WRITE: res_we=1 for exactly one cycle, with res_addr and res_data stable. Go to NEXT.
- NEXT:
  - res_addr increments by 1.
  - If mb_x == mb_cols-1: mb_x wraps to 0.
    - If mb_y == mb_rows-1 as well: go to FIN.
    - Otherwise mb_y increments and the FSM goes to LOAD.
  - Otherwise mb_x increments and the FSM goes to LOAD.
- FIN: done=1 for one cycle, busy=0 from the same cycle, then IDLE.
- Latency:
  - start to first load_req: 1 cycle.
  - me_ack to res_we: 1 cycle.
  - Per-MB overhead beyond the loader/ME waits: 3 cycles (WRITE, NEXT, LOAD entry).
- Handshake rules:
  - load_ack and me_ack are ignored in every state except the one awaiting them.
  - Loader and ME requests are never high in the same cycle.
  - mb_x/mb_y are stable from the first load_req cycle of an MB through its res_we.
- start while busy: ignored; latched dims are unchanged.
- An ack arriving in the same cycle its request first rises is accepted; minimum LOAD/SEARCH dwell is 1 cycle.
- Arithmetic:
  - Index compares use the latched dims.
  - res_addr is a free counter, never a multiply, and wraps modulo 2^RES_AW. That wrap is unreachable under the RES_AW parameter rule.

Optional Feature:
- Macro: ME_SAD_ACCUM_EN.
- Defined:
  - Adds output sum_sad [31:0], reset 0 and cleared on accepted start.
  - Adds me_min_sad to sum_sad in the WRITE cycle.
  - Saturates at 0xFFFFFFFF.
  - Holds its value after done until the next start.
- Undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- 2x2 frame:
  - Stimulus: mb_cols=2, mb_rows=2. load_ack 3 cycles after load_req. me_ack 10 cycles after me_req, with sad=0x0100+n, mvec=0x0A0+n.
  - Required: 4 res_we pulses at addr 0..3 with data {0x0100+n, 0x0A0+n}. Coordinates (0,0),(1,0),(0,1),(1,1). Exactly one done pulse, busy low in the same cycle.
- Empty frame: mb_cols=0, mb_rows=5, start.
  - Required: done 2 cycles after start; load_req, me_req and res_we never asserted.
- Start during busy: second start pulse while in SEARCH with mb_cols=7.
  - Required: ignored; frame still finishes after 4 MBs with the original 2x2 dims.
- Reset mid-operation: rst_n low while me_req=1.
  - Required: all outputs 0 asynchronously. After release the FSM is in IDLE, and a following me_ack produces no res_we.
- Spurious and same-cycle acks:
  - me_ack pulsed in IDLE and during LOAD: ignored, with no state change.
  - load_ack high in the first load_req cycle: me_req rises next cycle.
- ME_SAD_ACCUM_EN:
  - 1x3 frame with sad 0xFFFF each: sum_sad=0x0002FFFD after done.
  - Preloading the accumulator near 0xFFFFFFFF via force must clamp at 0xFFFFFFFF.
